ex_mem_buffer: RTL and testbench

//  Execute->memory pipeline buffer directly downstream of the ALU. Captures the ALU result,
//  Z flag and writeback/memory control each cycle and presents them to the memory stage.
//  Two-entry skid buffer with valid/ready handshake on both sides. Fully registered

---
 rtl/ex_mem_buffer.sv | 147 ++++++++++++++
 tb/tb_ex_mem_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_buffer.sv
// Execute->memory two-entry skid buffer with registered valid/ready on both sides.
// Optional EXMEM_FWD_EN macro adds result-forwarding outputs taken from the held entries.
module ex_mem_buffer #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_rc,
   input  logic            i_z,
   input  logic [RD_W-1:0] i_rd,
   input  logic            i_wb_en,
   input  logic            i_mem_rd,
   input  logic            i_mem_wr,
   input  logic [XLEN-1:0] i_store_data,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_rc,
   output logic            o_z,
   output logic [RD_W-1:0] o_rd,
   output logic            o_wb_en,
   output logic            o_mem_rd,
   output logic            o_mem_wr,
`ifdef EXMEM_FWD_EN
   output logic            o_fwd_valid,
   output logic [RD_W-1:0] o_fwd_rd,
   output logic [XLEN-1:0] o_fwd_data,
   output logic            o_fwd_stall,
`endif
   output logic [XLEN-1:0] o_store_data
);

   typedef struct packed {
      logic [XLEN-1:0] rc;
      logic            z;
      logic [RD_W-1:0] rd;
      logic            wb_en;
      logic            mem_rd;
      logic            mem_wr;
      logic [XLEN-1:0] sd;
   } entry_t;

   entry_t in_e;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_vld_q, out_vld_d;
   logic   skid_vld_q, skid_vld_d;
   logic   rdy_q, rdy_d;
   logic   accept, drain;

   assign in_e   = '{rc: i_rc, z: i_z, rd: i_rd, wb_en: i_wb_en,
                     mem_rd: i_mem_rd, mem_wr: i_mem_wr, sd: i_store_data};
   assign accept = i_valid & rdy_q;
   assign drain  = out_vld_q & i_ready;

   // SKID only fills while OUT is stalled, so a valid SKID always means OUT is valid too.
   always_comb begin
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      out_d      = out_q;
      skid_d     = skid_q;
      if (i_flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!out_vld_q || drain) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            out_d     = in_e;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = in_e;
         skid_vld_d = 1'b1;
      end
      rdy_d = ~skid_vld_d;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b1;
         out_q      <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= rdy_d;
         out_q      <= out_d;
      end
   end

   // SKID data is never observed unless its valid bit is set, so it carries no reset.
   always_ff @(posedge i_clk) begin
      skid_q <= skid_d;
   end

   assign o_ready      = rdy_q;
   assign o_valid      = out_vld_q;
   assign o_rc         = out_q.rc;
   assign o_z          = out_q.z;
   assign o_rd         = out_q.rd;
   assign o_wb_en      = out_q.wb_en;
   assign o_mem_rd     = out_q.mem_rd;
   assign o_mem_wr     = out_q.mem_wr;
   assign o_store_data = out_q.sd;

`ifdef EXMEM_FWD_EN
   logic skid_wr, out_wr, skid_ld, out_ld;

   assign skid_wr = skid_vld_q & skid_q.wb_en & (skid_q.rd != '0);
   assign out_wr  = out_vld_q & out_q.wb_en & (out_q.rd != '0);
   assign skid_ld = skid_wr & skid_q.mem_rd;
   assign out_ld  = out_wr & out_q.mem_rd;

   // A load younger than the ALU source with the same rd makes that source stale.
   always_comb begin
      o_fwd_valid = 1'b0;
      o_fwd_rd    = '0;
      o_fwd_data  = '0;
      o_fwd_stall = 1'b0;
      if (skid_wr && !skid_q.mem_rd) begin
         o_fwd_valid = 1'b1;
         o_fwd_rd    = skid_q.rd;
         o_fwd_data  = skid_q.rc;
      end else if (out_wr && !out_q.mem_rd) begin
         if (skid_ld && (skid_q.rd == out_q.rd)) begin
            o_fwd_stall = 1'b1;
         end else begin
            o_fwd_valid = 1'b1;
            o_fwd_rd    = out_q.rd;
            o_fwd_data  = out_q.rc;
         end
      end else begin
         o_fwd_stall = skid_ld | out_ld;
      end
   end
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Self-checking bench for ex_mem_buffer: directed scenarios plus randomized traffic
// compared against a bounded-FIFO reference model.
module tb_ex_mem_buffer;

   localparam int XLEN = 32;
   localparam int RD_W = 5;

   typedef struct packed {
      logic [XLEN-1:0] rc;
      logic            z;
      logic [RD_W-1:0] rd;
      logic            wb_en;
      logic            mem_rd;
      logic            mem_wr;
      logic [XLEN-1:0] sd;
   } entry_t;

   logic            i_clk, i_rstn, i_flush, i_valid, i_ready;
   logic [XLEN-1:0] i_rc, i_store_data;
   logic            i_z, i_wb_en, i_mem_rd, i_mem_wr;
   logic [RD_W-1:0] i_rd;
   logic            o_ready, o_valid, o_z, o_wb_en, o_mem_rd, o_mem_wr;
   logic [XLEN-1:0] o_rc, o_store_data;
   logic [RD_W-1:0] o_rd;
`ifdef EXMEM_FWD_EN
   logic            o_fwd_valid, o_fwd_stall;
   logic [RD_W-1:0] o_fwd_rd;
   logic [XLEN-1:0] o_fwd_data;
`endif

   ex_mem_buffer #(.XLEN(XLEN), .RD_W(RD_W)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_rc(i_rc), .i_z(i_z), .i_rd(i_rd), .i_wb_en(i_wb_en),
      .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_store_data(i_store_data),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_rc(o_rc), .o_z(o_z), .o_rd(o_rd), .o_wb_en(o_wb_en),
      .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
`ifdef EXMEM_FWD_EN
      .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd),
      .o_fwd_data(o_fwd_data), .o_fwd_stall(o_fwd_stall),
`endif
      .o_store_data(o_store_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int     n_chk = 0;
   int     n_err = 0;
   entry_t q[$];
   entry_t last_head;
   entry_t last_obs;
   logic   was_stalled;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic entry_t obs();
      return '{rc: o_rc, z: o_z, rd: o_rd, wb_en: o_wb_en, mem_rd: o_mem_rd,
               mem_wr: o_mem_wr, sd: o_store_data};
   endfunction

   task automatic put(input logic v, input logic [XLEN-1:0] rc, input logic [RD_W-1:0] rd,
                      input logic wb, input logic mrd, input logic rdy, input logic fl);
      i_valid      = v;
      i_rc         = rc;
      i_rd         = rd;
      i_wb_en      = wb;
      i_mem_rd     = mrd;
      i_ready      = rdy;
      i_flush      = fl;
      i_z          = 1'($urandom);
      i_mem_wr     = 1'($urandom);
      i_store_data = $urandom;
   endtask

   // Reference: a FIFO of capacity two; ready whenever it holds fewer than two entries.
   task automatic model_edge();
      entry_t cur;
      bit     drn, acc;
      cur = '{rc: i_rc, z: i_z, rd: i_rd, wb_en: i_wb_en, mem_rd: i_mem_rd,
              mem_wr: i_mem_wr, sd: i_store_data};
      was_stalled = (q.size() > 0) && !i_ready && !i_flush;
      if (i_flush) begin
         q.delete();
      end else begin
         drn = (q.size() > 0) && i_ready;
         acc = i_valid && (q.size() < 2);
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(cur);
      end
      if (q.size() > 0) last_head = q[0];
   endtask

   task automatic compare_all();
      chk("valid", 96'(o_valid), 96'(q.size() > 0));
      chk("ready", 96'(o_ready), 96'(q.size() < 2));
      chk("data", 96'(obs()), 96'(last_head));
      if (was_stalled) chk("stable", 96'(obs()), 96'(last_obs));
      last_obs = obs();
   endtask

   task automatic step();
      @(posedge i_clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      i_rstn = 1'b0;
      #1;
      q.delete();
      last_head = '0;
      last_obs  = '0;
      chk("rst_valid", 96'(o_valid), 96'(0));
      chk("rst_ready", 96'(o_ready), 96'(1));
      chk("rst_rc", 96'(o_rc), 96'(0));
      #1;
      i_rstn = 1'b1;
   endtask

   initial begin
      was_stalled = 1'b0;
      put(1'b1, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      i_rstn = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      do_reset();

      // Test 1: first entry appears one edge after acceptance.
      put(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("t1_valid", 96'(o_valid), 96'(1));
      chk("t1_rc", 96'(o_rc), 96'h1234);
      chk("t1_rd", 96'(o_rd), 96'(5));
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();

      // Test 2: streaming with constant i_ready.
      for (int k = 1; k <= 8; k++) begin
         put(1'b1, XLEN'(k), 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
         step();
         chk("t2_rc", 96'(o_rc), 96'(k));
         chk("t2_ready", 96'(o_ready), 96'(1));
      end
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();

      // Test 3: backpressure fills SKID, then drains in order.
      put(1'b1, 32'hA, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      put(1'b1, 32'hB, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("t3_rc_held", 96'(o_rc), 96'hA);
      chk("t3_ready", 96'(o_ready), 96'(0));
      put(1'b1, 32'hBAD, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      chk("t3_rc_next", 96'(o_rc), 96'hB);
      chk("t3_ready_back", 96'(o_ready), 96'(1));
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();

      // Test 4: flush with SKID full discards everything including the incoming entry.
      put(1'b1, 32'hD, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      put(1'b1, 32'hE, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      put(1'b1, 32'hC, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      chk("t4_valid", 96'(o_valid), 96'(0));
      chk("t4_ready", 96'(o_ready), 96'(1));
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t4_no_c", 96'(o_rc), 96'hD);
      end

`ifdef EXMEM_FWD_EN
      // Test 6: forwarding picks the youngest ALU writer; rd=0 ignored; loads stall.
      put(1'b1, 32'h55, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      put(1'b1, 32'h66, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("t6_fwd_data", 96'(o_fwd_data), 96'h66);
      chk("t6_fwd_valid", 96'(o_fwd_valid), 96'(1));
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      put(1'b1, 32'h77, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("t6_rd0", 96'(o_fwd_valid), 96'(0));
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      put(1'b1, 32'h88, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("t6_stall", 96'(o_fwd_stall), 96'(1));
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
`endif

      // Test 5: random traffic against the reference FIFO, with one async reset mid-run.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         put($urandom_range(0, 3) != 0, $urandom, RD_W'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
         if (cyc == 5000) do_reset();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
